// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and helpers for the UART receive frame controller.
package uart_rx_ctrl_pkg;

  // Receive sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_e;

  // Character length encodings seen on cfg_char_len.
  localparam logic [1:0] CHAR_LEN_5 = 2'd0;
  localparam logic [1:0] CHAR_LEN_6 = 2'd1;
  localparam logic [1:0] CHAR_LEN_7 = 2'd2;
  localparam logic [1:0] CHAR_LEN_8 = 2'd3;

  // Number of data bits for a character length encoding (5..8).
  function automatic logic [3:0] char_len_bits(input logic [1:0] len);
    return 4'd5 + {2'b00, len};
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Sample-tick generator: one-clk tick every max(baud_div,1) clks, restartable.
module uart_baud_tick_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 restart,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] reload;

  // A divider of 0 behaves as 1, i.e. a tick on every clk.
  assign reload = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);

  // Restart suppresses the tick so the first period after a start edge is a full one.
  assign tick = (cnt_q == '0) && !restart;

  // Down-counter next state: reload on restart or on reaching zero.
  always_comb begin
    cnt_d = cnt_q - DIV_WIDTH'(1);
    if (restart || (cnt_q == '0)) begin
      cnt_d = reload;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive sequencer: synchronizes rx, times mid-bit samples, assembles frames and
// presents them on a valid/ready handshake with parity, framing and overrun status.
module uart_rx_frame_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned MAX_DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned DIV_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIV_WIDTH-1:0]      baud_div,
  input  logic [1:0]                cfg_char_len,
  input  logic                      cfg_parity_en,
  input  logic                      cfg_parity_odd,
  input  logic                      cfg_stop2,
  input  logic                      rx,
  input  logic                      rx_ready,
  output logic [MAX_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      parity_err,
  output logic                      framing_err,
  output logic                      overrun_err,
  output logic                      busy
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W  = $clog2(MAX_DATA_WIDTH);
  localparam logic [SCNT_W-1:0] SCNT_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

  rx_state_e                 state_q, state_d;
  logic [SCNT_W-1:0]         scnt_q, scnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [MAX_DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                      frame_perr_q, frame_perr_d;
  logic                      frame_ferr_q, frame_ferr_d;
  logic                      done_q, done_d;
  logic [1:0]                len_q, len_d;
  logic                      pen_q, pen_d, podd_q, podd_d, stop2_q, stop2_d;
  logic                      rx_meta_q, rx_sync_q, rx_prev_q;
  logic                      tick, restart;
  logic [IDX_W-1:0]          last_idx;

  logic [MAX_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      parity_err_q, parity_err_d;
  logic                      framing_err_q, framing_err_d;
  logic                      overrun_q, overrun_d;

  uart_baud_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .restart  (restart),
    .tick     (tick)
  );

  assign last_idx = IDX_W'(char_len_bits(len_q) - 4'd1);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Sequencer next state: bit timing, sampling, shifting and frame status.
  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    frame_perr_d = frame_perr_q;
    frame_ferr_d = frame_ferr_q;
    len_d        = len_q;
    pen_d        = pen_q;
    podd_d       = podd_q;
    stop2_d      = stop2_q;
    done_d       = 1'b0;
    restart      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Edge-triggered only, so a line stuck low (break) cannot retrigger.
        if (rx_prev_q && !rx_sync_q) begin
          state_d      = StStart;
          scnt_d       = '0;
          restart      = 1'b1;
          shreg_d      = '0;
          frame_perr_d = 1'b0;
          frame_ferr_d = 1'b0;
          len_d        = cfg_char_len;
          pen_d        = cfg_parity_en;
          podd_d       = cfg_parity_odd;
          stop2_d      = cfg_stop2;
        end
      end
      StStart: begin
        if (tick) begin
          if (scnt_q == SCNT_MID) begin
            if (rx_sync_q) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              scnt_d  = '0;
              idx_d   = '0;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      StData, StParity, StStop1, StStop2: begin
        if (tick) begin
          if (scnt_q == SCNT_LAST) begin
            scnt_d = '0;
            if (state_q == StData) begin
              shreg_d[idx_q] = rx_sync_q;
              if (idx_q == last_idx) begin
                state_d = pen_q ? StParity : StStop1;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end else if (state_q == StParity) begin
              frame_perr_d = ((^shreg_q) ^ rx_sync_q) != podd_q;
              state_d      = StStop1;
            end else begin
              if (!rx_sync_q) begin
                frame_ferr_d = 1'b1;
              end
              if ((state_q == StStop1) && stop2_q) begin
                state_d = StStop2;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      scnt_q       <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      frame_perr_q <= 1'b0;
      frame_ferr_q <= 1'b0;
      done_q       <= 1'b0;
      len_q        <= CHAR_LEN_8;
      pen_q        <= 1'b0;
      podd_q       <= 1'b0;
      stop2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      frame_perr_q <= frame_perr_d;
      frame_ferr_q <= frame_ferr_d;
      done_q       <= done_d;
      len_q        <= len_d;
      pen_q        <= pen_d;
      podd_q       <= podd_d;
      stop2_q      <= stop2_d;
    end
  end

  // Output handshake: load a completed frame if the slot is free or being drained this clk.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overrun_d     = 1'b0;
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d     = shreg_q;
        rx_valid_d    = 1'b1;
        parity_err_d  = frame_perr_q;
        framing_err_d = frame_ferr_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: serial frames are driven on rx, a frame-level model
// predicts what the consumer must see, and a per-cycle compare process checks it.
module tb_uart_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  cfg_char_len;
  logic        cfg_parity_en, cfg_parity_odd, cfg_stop2;
  logic        rx, rx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, framing_err, overrun_err, busy;

  uart_rx_frame_ctrl #(
    .MAX_DATA_WIDTH (8),
    .OVERSAMPLE     (16),
    .DIV_WIDTH      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_div       (baud_div),
    .cfg_char_len   (cfg_char_len),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .rx             (rx),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .parity_err     (parity_err),
    .framing_err    (framing_err),
    .overrun_err    (overrun_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int ovr_seen = 0;
  int exp_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: what a correct receiver reports for the bits put on the line.
  function automatic frame_t model_frame(input logic [7:0] d, input int bits, input bit pen,
                                         input bit podd, input bit par_sent, input bit s1,
                                         input bit s2, input bit two_stop);
    frame_t f;
    int ones = 0;
    f.data = 8'h00;
    for (int i = 0; i < bits; i++) begin
      f.data[i] = d[i];
      ones += int'(d[i]);
    end
    f.perr = pen && (((ones + int'(par_sent)) % 2) != int'(podd));
    f.ferr = !s1 || (two_stop && !s2);
    return f;
  endfunction

  // A completed frame is either queued for the consumer or lost to overrun.
  task automatic expect_frame(input frame_t f, input bit ready_at_done);
    if ((exp_q.size() > 0) && !ready_at_done) exp_ovr++;
    else exp_q.push_back(f);
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_clks();
    return 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  // Drive one frame using the current config; flip_par inverts the correct parity bit.
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit s1,
                            input bit s2, input bit ready_at_done);
    int bits = 5 + int'(cfg_char_len);
    int bc = bit_clks();
    int ones = 0;
    bit par;
    for (int i = 0; i < bits; i++) ones += int'(d[i]);
    par = ((ones % 2) == 1) ^ cfg_parity_odd ^ flip_par;
    drive(1'b0, bc);
    for (int i = 0; i < bits; i++) drive(d[i], bc);
    if (cfg_parity_en) drive(par, bc);
    expect_frame(model_frame(d, bits, cfg_parity_en, cfg_parity_odd, par, s1, s2, cfg_stop2),
                 ready_at_done);
    drive(s1, bc);
    if (cfg_stop2) drive(s2, bc);
    drive(1'b1, bc);
  endtask

  // Capture the next presented frame and the clks from busy falling to rx_valid rising.
  task automatic wait_valid(output logic [7:0] d, output logic pe, output logic fe,
                            output int lat);
    int fall_at = -100;
    logic prev_busy = 1'b0;
    d = 8'h00; pe = 1'b0; fe = 1'b0; lat = -1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if (prev_busy && !busy) fall_at = n;
      prev_busy = busy;
      if (rx_valid) begin
        d = rx_data; pe = parity_err; fe = framing_err; lat = n - fall_at;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL wait_valid timeout actual=no_valid required=valid @%0t", $time);
  endtask

  // Per-cycle compare of the presented frame against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_err) ovr_seen++;
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid actual=0x%0h required=none @%0t", rx_data, $time);
        end else begin
          check("cmp_data", 32'(rx_data), 32'(exp_q[0].data));
          check("cmp_perr", 32'(parity_err), 32'(exp_q[0].perr));
          check("cmp_ferr", 32'(framing_err), 32'(exp_q[0].ferr));
          if (rx_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic pe, fe;
    int lat;
    bit saw_busy;

    rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; baud_div = 16'd4;
    cfg_char_len = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_errs", {29'd0, parity_err, framing_err, overrun_err}, 0);
    rst = 1'b0;
    drive(1'b1, 20);

    // 1: 8N1 0xA5
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_valid(d, pe, fe, lat);
    join
    check("t1_data", 32'(d), 32'h A5);
    check("t1_errs", {30'd0, pe, fe}, 0);
    check("t1_latency", 32'(lat), 1);

    // 2: 7E1 0x41, correct then flipped parity
    cfg_char_len = 2'd2; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    fork
      send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_valid(d, pe, fe, lat);
    join
    check("t2a_data", 32'(d), 32'h41);
    check("t2a_perr", 32'(pe), 0);
    fork
      send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_valid(d, pe, fe, lat);
    join
    check("t2b_data", 32'(d), 32'h41);
    check("t2b_perr", 32'(pe), 1);

    // 3: 8N2 0x3C, second stop bit low
    cfg_char_len = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b1;
    fork
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
      wait_valid(d, pe, fe, lat);
    join
    check("t3_data", 32'(d), 32'h3C);
    check("t3_ferr", 32'(fe), 1);
    check("t3_perr", 32'(pe), 0);
    cfg_stop2 = 1'b0;

    // 4: start glitch of 3 sample ticks
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
    end
    rx = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
    end
    check("t4_saw_busy", 32'(saw_busy), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_valid", 32'(rx_valid), 0);

    // 5a: consumer stalled, second frame overruns
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_valid", 32'(rx_valid), 1);
    check("t5_data", 32'(rx_data), 32'h11);
    check("t5_ovr", 32'(ovr_seen), 1);

    // 5b: ready raised on the completion clk of 0x22
    fork
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
      begin
        int n = 0;
        while (!busy && n < 2000) begin @(posedge clk); #1; n++; end
        while (busy && n < 4000) begin @(posedge clk); #1; n++; end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        check("t5b_valid", 32'(rx_valid), 1);
        check("t5b_data", 32'(rx_data), 32'h22);
      end
    join
    drive(1'b1, 8);
    check("t5b_ovr", 32'(ovr_seen), 1);
    check("t5b_drained", 32'(exp_q.size()), 0);

    // 6: reset mid-DATA with a frame held, then a clean frame
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, bit_clks());
    drive(1'b1, bit_clks());
    drive(1'b0, bit_clks() / 2);
    check("t6_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    exp_q.delete();
    rx = 1'b1;
    #1;
    check("t6_rst_valid", 32'(rx_valid), 0);
    check("t6_rst_data", 32'(rx_data), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_errs", {29'd0, parity_err, framing_err, overrun_err}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rx_ready = 1'b1;
    drive(1'b1, 40);
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_valid(d, pe, fe, lat);
    join
    check("t6_data", 32'(d), 32'h5A);

    // 7: baud_div of 0 behaves as 1
    baud_div = 16'd0;
    fork
      send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_valid(d, pe, fe, lat);
    join
    check("t7_data", 32'(d), 32'h96);

    drive(1'b1, 20);
    check("end_ovr", 32'(ovr_seen), 32'(exp_ovr));
    check("end_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
